// File: rtl/rom_dl_sender.sv
// Streams a byte source into the 16-bit ioctl download bus: packs byte pairs
// little-endian, strobes ioctl_wr per word and honours the receiver's wait.
module rom_dl_sender #(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] length,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  input  logic              ioctl_wait,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_dout,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    IDLE, FILL_LO, FILL_HI, SEND, GUARD, HOLD, FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] remaining;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      remaining      <= '0;
      src_ready      <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      // Abort outranks every other event once a transfer is under way.
      if (state != IDLE && abort) begin
        state          <= IDLE;
        src_ready      <= 1'b0;
        ioctl_download <= 1'b0;
        busy           <= 1'b0;
        aborted        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (length != '0) begin
                remaining      <= length;
                ioctl_addr     <= '0;
                ioctl_download <= 1'b1;
                busy           <= 1'b1;
                src_ready      <= 1'b1;
                state          <= FILL_LO;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FILL_LO: begin
            if (src_valid) begin
              ioctl_dout[7:0] <= src_data;
              remaining       <= remaining - ADDR_W'(1);
              if (remaining > ADDR_W'(1)) begin
                state <= FILL_HI;
              end else begin
                // Odd length: pad the upper byte of the final word.
                ioctl_dout[15:8] <= 8'hFF;
                src_ready        <= 1'b0;
                ioctl_wr         <= 1'b1;
                state            <= SEND;
              end
            end
          end
          FILL_HI: begin
            if (src_valid) begin
              ioctl_dout[15:8] <= src_data;
              remaining        <= remaining - ADDR_W'(1);
              src_ready        <= 1'b0;
              ioctl_wr         <= 1'b1;
              state            <= SEND;
            end
          end
          SEND:  state <= GUARD;
          // The receiver's wait is registered, so it cannot be trusted yet.
          GUARD: state <= HOLD;
          HOLD: begin
            if (!ioctl_wait) begin
              ioctl_addr <= ioctl_addr + ADDR_W'(2);
              if (remaining != '0) begin
                src_ready <= 1'b1;
                state     <= FILL_LO;
              end else begin
                state <= FINISH;
              end
            end
          end
          FINISH: begin
            ioctl_download <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/rom_dl_sender.md
ROM_DL_SENDER -- requirements
Module: rom_dl_sender

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, the width of ioctl_addr and length.
REQ-002 SHALL have port clk_sys  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a download; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancels the transfer in progress.
REQ-006 SHALL have port length  input  ADDR_W  byte count, latched on an accepted start.
REQ-007 SHALL have port src_valid  input  1  source byte available.
REQ-008 SHALL have port src_data  input  8  source byte.
REQ-009 SHALL have port src_ready  output  1  byte accepted when src_valid and src_ready are both high.
REQ-010 SHALL have port ioctl_wait  input  1  receiver backpressure; high means the receiver is busy.
REQ-011 SHALL have port ioctl_download  output  1  download window active.
REQ-012 SHALL have port ioctl_wr  output  1  one-cycle word strobe.
REQ-013 SHALL have port ioctl_addr  output  ADDR_W  byte address of the current word; always even.
REQ-014 SHALL have port ioctl_dout  output  16  word data.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-017 SHALL have port aborted  output  1  one-cycle pulse on an abort.

Function
REQ-018 SHALL use the states IDLE, FILL_LO, FILL_HI, SEND, GUARD, HOLD and FINISH.
REQ-019 IDLE: start with length != 0 SHALL latch remaining=length, clear ioctl_addr to 0, raise ioctl_download and go to FILL_LO in the next cycle.
REQ-020 IDLE: start with length == 0 SHALL pulse done in the next cycle and SHALL NOT assert ioctl_download or ioctl_wr.
REQ-021 src_ready SHALL be high only in FILL_LO and FILL_HI.
REQ-022 FILL_LO: an accepted byte SHALL load ioctl_dout[7:0] and decrement remaining; the state SHALL go to FILL_HI if remaining was >1, otherwise to SEND with ioctl_dout[15:8]=8'hFF (odd-length pad).
REQ-023 FILL_HI: an accepted byte SHALL load ioctl_dout[15:8], decrement remaining and go to SEND.
REQ-024 Both fill states SHALL hold without change while src_valid is low.
REQ-025 SEND SHALL assert ioctl_wr for exactly one cycle, then go to GUARD.
REQ-026 GUARD SHALL last one cycle and ignore ioctl_wait, which covers the receiver's registered wait assertion; the state then goes to HOLD.
REQ-027 HOLD SHALL stay while ioctl_wait is high; when it is low, ioctl_addr SHALL add 2 and the state SHALL go to FILL_LO if remaining != 0, otherwise to FINISH.
REQ-028 ioctl_dout and ioctl_addr SHALL stay stable from SEND through the cycle in which HOLD exits.
REQ-029 FINISH SHALL drop ioctl_download, pulse done and return to IDLE, all in one cycle.
REQ-030 Byte order SHALL be little-endian: even-address byte on [7:0], odd-address byte on [15:8].
REQ-031 Minimum word period SHALL be 5 cycles (FILL_LO, FILL_HI, SEND, GUARD, HOLD) when src_valid is constantly high and ioctl_wait is released immediately.
REQ-032 abort in any non-IDLE state SHALL win over every other event: the next cycle SHALL be IDLE with ioctl_download=0, ioctl_wr=0 and aborted=1, and done SHALL NOT pulse.
REQ-033 abort in IDLE SHALL be ignored; start while busy SHALL be ignored.
REQ-034 start and abort in the same IDLE cycle SHALL be resolved as start accepted, abort ignored.
REQ-035 ioctl_addr arithmetic SHALL be ADDR_W bits wide and wrap modulo 2^ADDR_W without flagging.

Reset
REQ-036 Asserting reset_n low SHALL immediately force IDLE; ioctl_download, ioctl_wr, src_ready, busy, done and aborted go to 0, and ioctl_addr, ioctl_dout and remaining go to 0.
REQ-037 Reset mid-transfer SHALL produce no done or aborted pulse.
REQ-038 After release, the first start SHALL be accepted on the first rising edge on which reset_n is high.

Verification
REQ-039 Bench SHALL cover: length=4, bytes 01 02 03 04, wait always low -> two wr pulses (addr 0 dout 0x0201, addr 2 dout 0x0403), then done; ioctl_download high for 11 cycles.
REQ-040 Bench SHALL cover: length=3, bytes AA BB CC -> words 0xBBAA@0 and 0xFFCC@2; remaining=0 at FINISH.
REQ-041 Bench SHALL cover: ioctl_wait held high 7 cycles after the first wr -> no second wr, and addr/dout stable, until 1 cycle after wait falls.
REQ-042 Bench SHALL cover: src_valid low for 10 cycles in FILL_HI -> no wr, src_ready stays high, and the word is sent once the byte arrives.
REQ-043 Bench SHALL cover: abort while in HOLD -> next cycle IDLE, aborted=1, done=0, ioctl_download=0; a new start is then accepted with addr=0.
REQ-044 Bench SHALL cover: length=0 start -> done the next cycle, with no ioctl_download or ioctl_wr ever asserted.
